mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing the single-ported main memory between the CPU control unit (port 0) and a second bus master such as DMA or debug (port 1). It accepts at most one transaction per cycle, registers the winner onto the memory bus, and routes read data back with a valid strobe. It supports locked sequences, such as the two-store interrupt push, that must not be interleaved.

## Interface
- `LOCK_MAX`, 16: maximum cycles a port may hold the lock before forced release (≥2).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`/`req1`  in  1  transaction request, held until granted.
- `rw0`/`rw1`  in  1  1 = write, 0 = read.
- `addr0`/`addr1`  in  32  byte address, passed unmodified.
- `wdata0`/`wdata1`  in  32  write data.
- `lock0`/`lock1`  in  1  keep ownership after this transaction.
- `gnt0`/`gnt1`  out  1  combinational; high in the cycle the request is accepted.
- `rvalid0`/`rvalid1`  out  1  read data valid for this port this cycle.
- `rdata0`/`rdata1`  out  32  both driven directly from `mem_rdata`.
- `mem_addr`  out  32  registered memory address.
- `mem_wdata`  out  32  registered write data.
- `mem_rw`  out  1  registered; 1 = write this cycle.
- `mem_rdata`  in  32  memory read data, valid the cycle after the address cycle.
- `lock_err`  out  1  one-cycle pulse on forced lock release.

## Operation
- **Acceptance.** A request is accepted at edge E when `reqN` is high and `gntN` is high in the preceding cycle. The requester may present a new request in the very next cycle; back-to-back grants are allowed.
- **Grant logic.** `gnt` is combinational from `req*`, the owner state and the RR pointer.
  - At most one `gnt` is high in any cycle.
  - Both `gnt` outputs are 0 while `reset` is high.
- **Owner states.**
  - `FREE`: round-robin. `rr` names the preferred port; on a tie, grant port `rr`.
  - After any grant, `rr` moves to the other port. Without a grant, `rr` holds.
  - Reset sets `rr` = 0 (CPU preferred).
- **Lock entry.** In `FREE`, a transaction accepted with `lockN` = 1 moves the state to `OWN_N` and clears `lock_cnt`.
- **Locked behaviour.** In `OWN_N`, only port N can be granted; the other port's requests wait.
  - A granted owner transaction with `lockN` = 0 completes and returns the state to `FREE`.
  - An owner presenting `reqN` = 0 with `lockN` = 0 also returns the state to `FREE`.
- **Lock timeout.** `lock_cnt` increments every cycle in `OWN_N`.
  - When it reaches `LOCK_MAX` − 1, the next edge forces `FREE` and pulses `lock_err` high for one cycle.
  - An owner grant in that same cycle is still honoured.
- **Memory issue.** At the acceptance edge:
  - `mem_addr` and `mem_wdata` load the winner's address and data.
  - `mem_rw` loads the winner's `rw`.
  - A 1-bit register records the issuing port.
- **Idle bus.** In a cycle with no acceptance, `mem_rw` = 0 and `mem_addr`/`mem_wdata` hold their previous values. No spurious writes are possible.
- **Read return.** A read accepted at E0 raises `rvalidN` of the issuing port for exactly one cycle after E1. That is the cycle in which `mem_rdata` is valid. `rvalid` of the other port stays 0.
- **Writes.** A write produces no `rvalid`.

## Timing
- Grant: 0 cycles (combinational, same cycle as `req`).
- Memory bus: driven 1 cycle after acceptance.
- Read data: valid 2 cycles after acceptance. Throughput is one transaction per cycle, aggregate.
- Reset values: `mem_addr` = 0, `mem_wdata` = 0, `mem_rw` = 0, `rvalid0` = `rvalid1` = 0, `lock_err` = 0, `rr` = 0, state `FREE`, `lock_cnt` = 0.
- Reset mid-operation:
  - Reset high at E1 after a read accepted at E0 suppresses that `rvalid`.
  - A write driven during the cycle before the reset edge is still captured by memory.
  - All locks clear without a `lock_err` pulse.
- Simultaneous events:
  - Lock request by both ports in `FREE`: only the RR winner becomes owner; the loser is not granted.
  - Owner unlock and other-port request in the same cycle: the other port is granted in the following cycle, not the same cycle.
- Wrap-around: `lock_cnt` never exceeds `LOCK_MAX` − 1. `addr` has no width conversion or alignment; alignment is the requester's responsibility.

## Test plan
- After reset, `req0` read 0x100 and `req1` read 0x200 every cycle → `gnt0`,`gnt1` alternate 0,1,0,1. Each `rvalid` appears 2 cycles after its grant, with `rdata` = memory contents.
- `req1` only, write 0xDEADBEEF to 0x40, then read 0x40 → `mem_rw` = 1 for one cycle, then the read returns 0xDEADBEEF on `rdata1` with `rvalid0` = 0.
- Port 0 issues locked write 0x1FC (`lock0` = 1), then unlocked write 0x1F8, while `req1` is held high → `gnt1` = 0 until the cycle after the second write is accepted, then `gnt1` = 1.
- `LOCK_MAX` = 4: port 1 locks, then idles with `lock1` = 1 and `req1` = 0; `req0` held high → `lock_err` pulses 4 cycles after lock acceptance and `gnt0` = 1 in the following cycle.
- Read accepted, `reset` asserted at the next edge → no `rvalid` and all outputs at reset values. The first request after reset is granted to port 0 on a tie.
- No requests for 10 cycles → `mem_rw` stays 0, `mem_addr` holds the last value, and `gnt`/`rvalid` stay 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-ported memory between the CPU (port 0) and a
// second master (port 1), with round-robin fairness and time-limited locked sequences.
module mem_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        rw0,
  input  logic        rw1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata,
  output logic        lock_err
);

  localparam int CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  typedef enum logic [1:0] {FREE, OWN0, OWN1} state_e;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_err_q, lock_err_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_rw_q, mem_rw_d;
  logic          rd_q, rd_d;
  logic          port_q, port_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          own_lock;

  // Grant: round-robin tie-break when free, owner-only when locked
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state_q)
        FREE: begin
          if (req0 && (!req1 || !rr_q)) gnt0 = 1'b1;
          else if (req1)                gnt1 = 1'b1;
        end
        OWN0:    gnt0 = req0;
        OWN1:    gnt1 = req1;
        default: ;
      endcase
    end
  end

  assign own_lock = (state_q == OWN0) ? lock0 : lock1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lock_err_d = 1'b0;
    rr_d       = rr_q;
    if (gnt0)      rr_d = 1'b1;
    else if (gnt1) rr_d = 1'b0;
    case (state_q)
      FREE: begin
        cnt_d = '0;
        if (gnt0 && lock0)      state_d = OWN0;
        else if (gnt1 && lock1) state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = FREE;
          cnt_d      = '0;
          lock_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // An owner dropping lock releases whether or not it is transacting
          if (!own_lock) state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rw_d    = 1'b0;
    rd_d        = 1'b0;
    port_d      = port_q;
    if (gnt0 || gnt1) begin
      mem_addr_d  = gnt1 ? addr1  : addr0;
      mem_wdata_d = gnt1 ? wdata1 : wdata0;
      mem_rw_d    = gnt1 ? rw1    : rw0;
      rd_d        = gnt1 ? !rw1   : !rw0;
      port_d      = gnt1;
    end
    rvalid0_d = rd_q && !port_q;
    rvalid1_d = rd_q && port_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FREE;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      lock_err_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rw_q    <= 1'b0;
      rd_q        <= 1'b0;
      port_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      lock_err_q  <= lock_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rw_q    <= mem_rw_d;
      rd_q        <= rd_d;
      port_q      <= port_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rw    = mem_rw_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign lock_err  = lock_err_q;
  assign rdata0    = mem_rdata;
  assign rdata1    = mem_rdata;

endmodule
